act_arbiter: RTL and testbench
==============================

ACT_ARBITER -- requirements
Module: act_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one activation unit (2..8).
REQ-002 Parameter DW, default 12, activation input width per requester.
REQ-003 Parameter OW, default 5, activation output width.
REQ-004 Parameter CW, default 16, result counter width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  N_REQ  per-requester request valid.
REQ-008 req_data  input  N_REQ*DW  flattened operands; requester i occupies bits [i*DW +: DW].
REQ-009 req_ready  output  N_REQ  per-requester accept strobe, combinational.
REQ-010 res_valid  output  1  result register holds a valid result.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res_data  output  OW  registered activation output.
REQ-013 res_id  output  clog2(N_REQ)  index of the requester that produced res_data.
REQ-014 res_count  output  CW  number of results consumed since reset.

Function
REQ-015 Block SHALL contain a 2-state FSM: EMPTY (no held result) and FULL (result held, res_valid=1).
REQ-016 can_accept SHALL equal (state==EMPTY) or (state==FULL and res_ready).
REQ-017 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod N_REQ, first asserted req_valid wins.
REQ-018 At most one req_ready bit SHALL be high per cycle, only for the winner and only when can_accept=1.
REQ-019 req_ready SHALL NOT depend on req_data.
REQ-020 On accept (req_valid[g] & req_ready[g]), the winner's operand SHALL pass through one combinational activation instance; its output SHALL be registered into res_data and g into res_id on the same edge; latency from accept to res_valid is 1 cycle.
REQ-021 last_grant SHALL update to g only on accept; no accept leaves it unchanged.
REQ-022 Transitions: EMPTY->FULL on accept; FULL->EMPTY on res_ready without accept; FULL->FULL on stall, or on res_ready with simultaneous accept (back-to-back, res_valid stays 1, new data loaded).
REQ-023 While FULL and res_ready=0, res_data and res_id SHALL remain stable.
REQ-024 res_count SHALL increment by 1 on each cycle with res_valid & res_ready and wrap from 2^CW-1 to 0.
REQ-025 Full throughput: with continuous requests and res_ready=1, one result SHALL be delivered every cycle.
REQ-026 A requester whose req_valid drops before grant SHALL simply be skipped; no state is kept per requester.

Reset
REQ-027 On rst=1 at a clock edge: state=EMPTY, res_valid=0, res_data=0, res_id=0, res_count=0, last_grant=N_REQ-1 (so requester 0 has first priority).
REQ-028 req_ready SHALL be all-zero while rst=1.
REQ-029 Reset mid-operation SHALL discard any held result without asserting res_valid afterward.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (EMPTY=0, FULL=1) and default widths DW=12, OW=5.
REQ-031 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, last_grant; outputs one-hot grant, grant index).
REQ-032 The existing Activation module (data_in DW, data_out OW) SHALL be instantiated exactly once, unmodified.

Verification
REQ-033 Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=0000, res_valid=0, res_count=0.
REQ-034 Single request: req_valid=0100, data2=12'b010101001001, res_ready=1 -> req_ready=0100 that cycle; next cycle res_valid=1, res_id=2, res_data equals golden Activation(12'b010101001001).
REQ-035 Fairness: req_valid=1111 held, res_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, res_count=8 after the last handshake.
REQ-036 Backpressure: FULL with res_id=1, res_ready=0 for 5 cycles, req_valid=1111 -> req_ready=0000, res_data/res_id unchanged; on res_ready=1 -> requester 2 granted in that same cycle, res_valid stays 1.
REQ-037 Wrap: CW=4, 17 consumed results -> res_count=1.
REQ-038 Mid-operation reset: FULL state with res_id=3, rst=1 one cycle -> res_valid=0; next grant with req_valid=1111 goes to requester 0.

Source files
------------

// File: rtl/act_arbiter_pkg.sv
// Shared definitions for the activation arbiter slice.
// Holds the result-register FSM encoding, the default widths, and a helper
// that sizes requester-index fields. No ports (package).
package act_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,   // no result held
        FULL  = 1'b1    // result held, res_valid=1
    } state_e;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_DW    = 12;
    localparam int DEF_OW    = 5;
    localparam int DEF_CW    = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/act_arbiter_if.sv
// Requester/result bus of the activation arbiter.
//   req_valid [N_REQ]      per-requester request valid
//   req_data  [N_REQ*DW]   operands, requester i at [i*DW +: DW]
//   req_ready [N_REQ]      one-hot accept strobe (combinational)
//   res_valid / res_ready  result handshake
//   res_data  [OW]         registered activation output
//   res_id    [IW]         requester that produced res_data
//   res_count [CW]         results consumed since reset
// master = requesters + consumer side, slave = arbiter.
interface act_arbiter_if
    import act_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW,
    parameter int OW    = DEF_OW,
    parameter int CW    = DEF_CW
) ();
    localparam int IW = idx_w(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                res_valid;
    logic                res_ready;
    logic [OW-1:0]       res_data;
    logic [IW-1:0]       res_id;
    logic [CW-1:0]       res_count;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_count
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, res_count
    );
endinterface

// File: rtl/Activation.sv
// Activation unit: saturating ReLU from a signed DW-bit operand to an
// unsigned OW-bit result. Negative -> 0; magnitude beyond OW bits -> all
// ones; otherwise the low OW bits pass through. Requires DW >= OW+2.
//   data_in  [DW]  signed operand
//   data_out [OW]  activation result (combinational)
module Activation #(
    parameter int DW = 12,
    parameter int OW = 5
) (
    input  logic [DW-1:0] data_in,
    output logic [OW-1:0] data_out
);
    always_comb begin
        if (data_in[DW-1])
            data_out = '0;
        else if (|data_in[DW-2:OW])
            data_out = '1;
        else
            data_out = data_in[OW-1:0];
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past last_grant (wrapping) and the
// first asserted request wins.
//   req        [N_REQ]  request vector
//   last_grant [IW]     index granted most recently
//   grant      [N_REQ]  one-hot grant, zero when no request
//   grant_idx  [IW]     index of the granted bit (0 when none)
module rr_arbiter
    import act_arbiter_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);
    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // k=N_REQ wraps back to last_grant itself, so it is searched last.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req[IW'(idx)]) begin
                found              = 1'b1;
                grant[IW'(idx)]    = 1'b1;
                grant_idx          = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/act_arbiter.sv
// Shares one activation unit among N_REQ requesters. A round-robin winner
// is accepted whenever the single-entry result register is empty or being
// drained in the same cycle, so continuous traffic yields one result per
// cycle. res_count tallies consumed results and wraps.
//   clk, rst   clock, synchronous active-high reset
//   bus        act_arbiter_if.slave (request and result handshakes)
module act_arbiter
    import act_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW,
    parameter int OW    = DEF_OW,
    parameter int CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    act_arbiter_if.slave  bus
);
    localparam int IW = idx_w(N_REQ);

    state_e           state;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    res_id_q;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ready;
    logic             can_accept;
    logic             accept;
    logic [DW-1:0]    operand;
    logic [OW-1:0]    act_out;
    logic [OW-1:0]    res_data_q;
    logic [CW-1:0]    count_q;

    // Grant looks only at req_valid, never at operand data.
    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign can_accept = (state == EMPTY) || (state == FULL && bus.res_ready);
    assign ready      = (can_accept && !rst) ? grant : '0;
    // grant bits are only ever set for asserted req_valid bits
    assign accept     = |ready;

    assign operand = bus.req_data[int'(grant_idx)*DW +: DW];

    Activation #(.DW(DW), .OW(OW)) u_act (
        .data_in  (operand),
        .data_out (act_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            res_data_q <= '0;
            res_id_q   <= '0;
            count_q    <= '0;
            last_grant <= IW'(N_REQ-1);
        end else begin
            if (state == FULL && bus.res_ready)
                count_q <= count_q + 1'b1;

            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (bus.res_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            // Only an accept moves the result register and the RR pointer;
            // while stalled accept is 0, so the held result stays put.
            if (accept) begin
                res_data_q <= act_out;
                res_id_q   <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.res_valid = (state == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_count = count_q;
endmodule

// File: tb/tb_act_arbiter.sv
// Bench for act_arbiter: table of per-cycle vectors plus a reset/wrap
// sequence; result id/data are tracked by a scoreboard queue.
module tb_act_arbiter;
    localparam int N  = 4;
    localparam int DW = 12;
    localparam int OW = 5;
    localparam int CW = 4;

    localparam logic [N*DW-1:0] DAT = {12'h80F, 12'b010101001001, 12'h00A, 12'h013};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    act_arbiter_if #(.N_REQ(N), .DW(DW), .OW(OW), .CW(CW)) bus ();

    act_arbiter #(.N_REQ(N), .DW(DW), .OW(OW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic            rst;
        logic [N-1:0]    rv;
        logic [N*DW-1:0] data;
        logic            rr;
        logic [N-1:0]    exp_rdy;
        logic            exp_vld;
        logic [CW-1:0]   exp_cnt;
    } vec_t;

    typedef struct {
        logic [1:0]    id;
        logic [OW-1:0] data;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic exp_full = 1'b0;

    // Golden saturating ReLU for DW=12, OW=5.
    function automatic logic [OW-1:0] act_ref(input logic [DW-1:0] x);
        if (x[11])           return 5'd0;
        if (x[10:5] != 6'd0) return 5'd31;
        return x[4:0];
    endfunction

    function automatic vec_t mk(input logic r, input logic [N-1:0] rv, input logic [N*DW-1:0] d,
                                input logic rr, input logic [N-1:0] rdy, input logic vld,
                                input logic [CW-1:0] cnt);
        vec_t v;
        v.rst = r; v.rv = rv; v.data = d; v.rr = rr;
        v.exp_rdy = rdy; v.exp_vld = vld; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1: drive, check comb ready and held result,
    // update scoreboard, then check registered outputs after the edge.
    task automatic do_cycle(input vec_t v, input string tag);
        res_t r;
        int   g;
        rst           = v.rst;
        bus.req_valid = v.rv;
        bus.req_data  = v.data;
        bus.res_ready = v.rr;
        #1;
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(v.exp_rdy));
        if (exp_full && !v.rst) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s sb: result held but none expected", tag);
            end else begin
                chk({tag, " res_id"},   32'(bus.res_id),   32'(sb[0].id));
                chk({tag, " res_data"}, 32'(bus.res_data), 32'(sb[0].data));
                if (v.rr) void'(sb.pop_front());
            end
        end
        if (v.rst) begin
            sb.delete();
        end else if (v.exp_rdy != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (v.exp_rdy[i]) g = i;
            r.id   = g[1:0];
            r.data = act_ref(v.data[g*DW +: DW]);
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        chk({tag, " res_valid"}, 32'(bus.res_valid), 32'(v.exp_vld));
        chk({tag, " res_count"}, 32'(bus.res_count), 32'(v.exp_cnt));
        exp_full = v.exp_vld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[27];
        logic [63:0] rnd;

        tbl[0]  = mk(1, 4'b1111, DAT, 0, 4'b0000, 0, 0);   // reset, 2 cycles
        tbl[1]  = mk(1, 4'b1111, DAT, 0, 4'b0000, 0, 0);
        tbl[2]  = mk(0, 4'b1111, DAT, 1, 4'b0001, 1, 0);   // fairness 0,1,2,3,0,1,2,3
        tbl[3]  = mk(0, 4'b1111, DAT, 1, 4'b0010, 1, 1);
        tbl[4]  = mk(0, 4'b1111, DAT, 1, 4'b0100, 1, 2);
        tbl[5]  = mk(0, 4'b1111, DAT, 1, 4'b1000, 1, 3);
        tbl[6]  = mk(0, 4'b1111, DAT, 1, 4'b0001, 1, 4);
        tbl[7]  = mk(0, 4'b1111, DAT, 1, 4'b0010, 1, 5);
        tbl[8]  = mk(0, 4'b1111, DAT, 1, 4'b0100, 1, 6);
        tbl[9]  = mk(0, 4'b1111, DAT, 1, 4'b1000, 1, 7);
        tbl[10] = mk(0, 4'b0000, DAT, 1, 4'b0000, 0, 8);   // 8th handshake
        tbl[11] = mk(0, 4'b0100, DAT, 1, 4'b0100, 1, 8);   // single request, id 2
        tbl[12] = mk(0, 4'b0000, DAT, 1, 4'b0000, 0, 9);
        tbl[13] = mk(0, 4'b1001, DAT, 0, 4'b1000, 1, 9);   // 3 after last=2
        tbl[14] = mk(0, 4'b0011, DAT, 0, 4'b0000, 1, 9);   // stall
        tbl[15] = mk(0, 4'b0010, DAT, 1, 4'b0010, 1, 10);  // back-to-back, 0 dropped
        for (int i = 16; i <= 20; i++)
            tbl[i] = mk(0, 4'b1111, DAT, 0, 4'b0000, 1, 10); // backpressure, id 1 held
        tbl[21] = mk(0, 4'b1111, DAT, 1, 4'b0100, 1, 11);  // release -> 2
        tbl[22] = mk(0, 4'b1000, DAT, 1, 4'b1000, 1, 12);  // FULL with id 3
        tbl[23] = mk(1, 4'b1111, DAT, 0, 4'b0000, 0, 0);   // mid-operation reset
        tbl[24] = mk(0, 4'b0000, DAT, 1, 4'b0000, 0, 0);   // held result discarded
        tbl[25] = mk(0, 4'b1111, DAT, 1, 4'b0001, 1, 0);   // priority back at 0
        tbl[26] = mk(0, 4'b0000, DAT, 1, 4'b0000, 0, 1);

        // Scramble operands on odd rows; row 11 keeps its fixed operand.
        for (int i = 1; i < 27; i += 2) begin
            if (i != 11) begin
                rnd = {$urandom, $urandom};
                tbl[i].data = rnd[N*DW-1:0];
            end
        end

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++)
            do_cycle(tbl[i], $sformatf("row%0d", i));

        // Counter wrap: 17 consumed results from reset -> count 1.
        do_cycle(mk(1, 4'b1111, DAT, 0, 4'b0000, 0, 0), "wrap_rst");
        for (int k = 1; k <= 17; k++) begin
            rnd = {$urandom, $urandom};
            do_cycle(mk(0, 4'b1111, rnd[N*DW-1:0], 1, 4'(1 << ((k-1) % 4)), 1, 4'((k-1) % 16)),
                     $sformatf("wrap%0d", k));
        end
        do_cycle(mk(0, 4'b0000, DAT, 1, 4'b0000, 0, 1), "wrap_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
